// File: rtl/text_char_buffer.sv
// Writable COLS x ROWS character grid for the text layer: random-access writes,
// cursor-driven put stream with auto-advance/newline, and a fill-code clear engine.
module text_char_buffer #(
  parameter int                 COL_BITS  = 4,
  parameter int                 ROW_BITS  = 4,
  parameter int                 CODE_W    = 7,
  parameter logic [CODE_W-1:0]  FILL_CODE = 7'h20,
  localparam int                XY_W      = COL_BITS + ROW_BITS
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic              wr_en,
  input  logic [XY_W-1:0]   wr_xy,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              cur_set,
  input  logic [XY_W-1:0]   cur_xy,
  input  logic              put_en,
  input  logic [CODE_W-1:0] put_code,
  output logic [XY_W-1:0]   cursor_xy,
  input  logic [XY_W-1:0]   rd_xy,
  output logic [CODE_W-1:0] rd_code
);

  localparam int                CELLS   = 1 << XY_W;
  localparam logic [CODE_W-1:0] NEWLINE = CODE_W'(7'h0A);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_reg;
  logic [XY_W-1:0]     clr_addr_reg;
  logic [XY_W-1:0]     cursor_reg;
  logic                busy_reg;
  logic                rd_fill_reg;
  logic [CODE_W-1:0]   rd_data_reg;
  logic [CODE_W-1:0]   mem [CELLS];

  logic                put_accept;
  logic                put_is_nl;
  logic [XY_W-1:0]     cursor_adv;
  logic [XY_W-1:0]     cursor_nl;
  logic [ROW_BITS-1:0] cursor_row;
  logic                mem_we;
  logic [XY_W-1:0]     mem_waddr;
  logic [CODE_W-1:0]   mem_wdata;

  // A put only lands when nothing of higher priority claims the RAM or cursor.
  assign put_accept = (state_reg == IDLE) && !clear && put_en && !wr_en && !cur_set;
  assign put_is_nl  = (put_code == NEWLINE);
  assign cursor_row = cursor_reg[XY_W-1:COL_BITS];
  assign cursor_adv = cursor_reg + XY_W'(1);
  assign cursor_nl  = {cursor_row + ROW_BITS'(1), {COL_BITS{1'b0}}};

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr_reg;
    mem_wdata = FILL_CODE;
    if (!rst && !clear) begin
      if (state_reg == CLEAR) begin
        mem_we = 1'b1;
      end else if (wr_en) begin
        mem_we    = 1'b1;
        mem_waddr = wr_xy;
        mem_wdata = wr_code;
      end else if (put_accept && !put_is_nl) begin
        mem_we    = 1'b1;
        mem_waddr = cursor_reg;
        mem_wdata = put_code;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
      cursor_reg   <= '0;
      busy_reg     <= 1'b1;
      rd_fill_reg  <= 1'b1;
    end else begin
      rd_fill_reg <= (state_reg == CLEAR);
      if (clear) begin
        state_reg    <= CLEAR;
        clr_addr_reg <= '0;
        cursor_reg   <= '0;
        busy_reg     <= 1'b1;
      end else begin
        case (state_reg)
          CLEAR: begin
            clr_addr_reg <= clr_addr_reg + XY_W'(1);
            if (clr_addr_reg == {XY_W{1'b1}}) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
          IDLE: begin
            if (cur_set) begin
              cursor_reg <= cur_xy;
            end else if (put_accept) begin
              cursor_reg <= put_is_nl ? cursor_nl : cursor_adv;
            end
          end
          default: state_reg <= CLEAR;
        endcase
      end
    end
  end

  // Plain RAM port, no reset: read-before-write on a shared address.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_reg <= mem[rd_xy];
  end

  assign busy      = busy_reg;
  assign cursor_xy = cursor_reg;
  assign rd_code   = rd_fill_reg ? FILL_CODE : rd_data_reg;

endmodule

// File: tb/tb_text_char_buffer.sv
// Self-checking bench for text_char_buffer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a grid model.
module tb_text_char_buffer;

  localparam int COL_BITS = 4;
  localparam int ROW_BITS = 4;
  localparam int CODE_W   = 7;
  localparam int XY_W     = COL_BITS + ROW_BITS;
  localparam int COLS     = 1 << COL_BITS;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int CELLS    = COLS * ROWS;
  localparam logic [CODE_W-1:0] FILL = 7'h20;

  logic              pclk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              busy;
  logic              wr_en = 1'b0;
  logic [XY_W-1:0]   wr_xy = '0;
  logic [CODE_W-1:0] wr_code = '0;
  logic              cur_set = 1'b0;
  logic [XY_W-1:0]   cur_xy = '0;
  logic              put_en = 1'b0;
  logic [CODE_W-1:0] put_code = '0;
  logic [XY_W-1:0]   cursor_xy;
  logic [XY_W-1:0]   rd_xy = '0;
  logic [CODE_W-1:0] rd_code;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  text_char_buffer #(
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS),
    .CODE_W   (CODE_W),
    .FILL_CODE(FILL)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .clear    (clear),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_xy    (wr_xy),
    .wr_code  (wr_code),
    .cur_set  (cur_set),
    .cur_xy   (cur_xy),
    .put_en   (put_en),
    .put_code (put_code),
    .cursor_xy(cursor_xy),
    .rd_xy    (rd_xy),
    .rd_code  (rd_code)
  );

  always #5 pclk = ~pclk;

  // Model: grid as an array, cursor as (row, col), clear as a remaining-write count.
  logic [CODE_W-1:0] m_mem [CELLS];
  int m_clr_left = CELLS;
  int m_fill_ptr = 0;
  int m_cursor   = 0;
  int m_rd       = FILL;

  task automatic model_step();
    int row, col, next_rd;
    if (rst) begin
      m_clr_left = CELLS;
      m_fill_ptr = 0;
      m_cursor   = 0;
      m_rd       = FILL;
      return;
    end
    next_rd = (m_clr_left > 0) ? int'(FILL) : int'(m_mem[rd_xy]);
    if (clear) begin
      m_clr_left = CELLS;
      m_fill_ptr = 0;
      m_cursor   = 0;
    end else if (m_clr_left > 0) begin
      m_mem[m_fill_ptr] = FILL;
      m_fill_ptr = (m_fill_ptr + 1) % CELLS;
      m_clr_left--;
    end else begin
      row = m_cursor / COLS;
      col = m_cursor % COLS;
      if (wr_en) m_mem[wr_xy] = wr_code;
      if (cur_set) begin
        m_cursor = int'(cur_xy);
      end else if (put_en && !wr_en) begin
        if (put_code == 7'h0A) begin
          col = 0;
          row = (row + 1) % ROWS;
        end else begin
          m_mem[m_cursor] = put_code;
          col = col + 1;
          if (col == COLS) begin
            col = 0;
            row = (row + 1) % ROWS;
          end
        end
        m_cursor = row * COLS + col;
      end
    end
    m_rd = next_rd;
  endtask

  initial forever begin
    @(posedge pclk or posedge rst);
    model_step();
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (cmp_on) begin
      check("busy", int'(busy), int'(m_clr_left > 0));
      check("cursor", int'(cursor_xy), m_cursor);
      check("rd_code", int'(rd_code), m_rd);
    end
  end

  task automatic idle();
    wr_en = 1'b0; put_en = 1'b0; cur_set = 1'b0; clear = 1'b0;
  endtask

  task automatic step();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic wait_idle(input string name, input int exp_edges);
    int n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  task automatic read_cell(input logic [XY_W-1:0] a, output int d);
    idle();
    rd_xy = a;
    step();
    d = int'(rd_code);
  endtask

  task automatic do_cur_set(input logic [XY_W-1:0] a);
    idle(); cur_set = 1'b1; cur_xy = a; step(); idle();
    $display("cur_set %02h -> cursor %02h", a, cursor_xy);
  endtask

  task automatic do_put(input logic [CODE_W-1:0] c);
    idle(); put_en = 1'b1; put_code = c; step(); idle();
    $display("put %02h -> cursor %02h", c, cursor_xy);
  endtask

  task automatic check_all_fill(input string name);
    int d;
    for (int i = 0; i < CELLS; i++) begin
      read_cell(XY_W'(i), d);
      check(name, d, int'(FILL));
    end
  endtask

  initial begin
    int d;
    repeat (3) @(negedge pclk);
    check("reset_busy", int'(busy), 1);
    check("reset_cursor", int'(cursor_xy), 0);
    check("reset_rd", int'(rd_code), 'h20);
    rst = 1'b0;
    cmp_on = 1'b1;
    wait_idle("post_reset_edges", 256);
    check_all_fill("init_cell");

    // random-access write, read-before-write then read-after-write
    idle(); wr_en = 1'b1; wr_xy = 8'h26; wr_code = 7'h4D; rd_xy = 8'h26;
    step(); idle();
    $display("wr 26 <= 4d, same-edge read %02h", rd_code);
    check("rbw_old", int'(rd_code), 'h20);
    step();
    check("wr_then_rd", int'(rd_code), 'h4D);

    // put stream with advance and full-grid wrap
    do_cur_set(8'h2E);
    do_put(7'h41); do_put(7'h42); do_put(7'h43);
    check("put_cursor", int'(cursor_xy), 'h31);
    read_cell(8'h2E, d); check("put_A", d, 'h41);
    read_cell(8'h2F, d); check("put_B", d, 'h42);
    read_cell(8'h30, d); check("put_C", d, 'h43);
    do_cur_set(8'hFF);
    do_put(7'h5A);
    check("put_wrap_cursor", int'(cursor_xy), 'h00);
    read_cell(8'hFF, d); check("put_Z", d, 'h5A);

    // newline
    do_cur_set(8'h35);
    do_put(7'h0A);
    check("nl_cursor", int'(cursor_xy), 'h40);
    read_cell(8'h35, d); check("nl_no_write", d, 'h20);
    do_cur_set(8'hF3);
    do_put(7'h0A);
    check("nl_wrap_cursor", int'(cursor_xy), 'h00);

    // priorities: wr_en beats put, cur_set beats put
    do_cur_set(8'h20);
    idle(); wr_en = 1'b1; wr_xy = 8'h10; wr_code = 7'h58; put_en = 1'b1; put_code = 7'h59;
    step(); idle();
    $display("wr 10 <= 58 with put 59 -> cursor %02h", cursor_xy);
    check("wr_put_cursor", int'(cursor_xy), 'h20);
    read_cell(8'h10, d); check("wr_put_cell10", d, 'h58);
    read_cell(8'h20, d); check("wr_put_cell20", d, 'h20);
    idle(); cur_set = 1'b1; cur_xy = 8'h50; put_en = 1'b1; put_code = 7'h51;
    step(); idle();
    check("cur_put_cursor", int'(cursor_xy), 'h50);
    read_cell(8'h20, d); check("cur_put_cell20", d, 'h20);
    read_cell(8'h50, d); check("cur_put_cell50", d, 'h20);

    // clear with a write attempt during busy
    idle(); clear = 1'b1; step(); idle();
    check("clear_busy", int'(busy), 1);
    wr_en = 1'b1; wr_xy = 8'h05; wr_code = 7'h4D; step(); idle();
    wait_idle("clear_edges", 255);
    check("clear_cursor", int'(cursor_xy), 0);
    check_all_fill("clear_cell");

    // reset in the middle of a clear
    do_cur_set(8'h77);
    idle(); clear = 1'b1; step(); idle();
    repeat (100) step();
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 1);
    check("midrst_cursor", int'(cursor_xy), 0);
    check("midrst_rd", int'(rd_code), 'h20);
    @(negedge pclk);
    rst = 1'b0;
    wait_idle("midrst_edges", 256);

    // randomized traffic, checked every cycle against the model
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 1999) == 0) begin
        #2 rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        continue;
      end
      clear    = ($urandom_range(0, 599) == 0);
      wr_en    = ($urandom_range(0, 9) < 3);
      wr_xy    = XY_W'($urandom);
      wr_code  = CODE_W'($urandom);
      cur_set  = ($urandom_range(0, 9) == 0);
      cur_xy   = XY_W'($urandom);
      put_en   = ($urandom_range(0, 9) < 5);
      put_code = ($urandom_range(0, 7) == 0) ? 7'h0A : CODE_W'($urandom);
      rd_xy    = ($urandom_range(0, 1) == 0) ? cursor_xy - XY_W'(1) : XY_W'($urandom);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
